bin_to_bcd_module: RTL
======================

# bin_to_bcd_module

- Converts an unsigned binary value (0–9999 nominal) into four packed BCD digits using iterative double-dabble, one shift per clock.
- Sits directly upstream of the four-digit seven-segment scan controller and drives its 16-bit `NumberSig` input.
- The converted value is held stable between conversions, so the scan controller can multiplex it at any rate.

## Interface
- `BIN_W`, default 14: width of the binary input; legal range 4..14.
- `CLK` in 1: system clock; all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `StartSig` in 1: request conversion of `BinData`; sampled only in IDLE.
- `BinData` in `BIN_W`: unsigned binary value, sampled on the accepting edge only.
- `NumberSig` out 16: packed BCD result, `[15:12]` thousands … `[3:0]` units; held until the next conversion completes.
- `DoneSig` out 1: one-cycle pulse marking that `NumberSig` has just updated.
- `BusySig` out 1: high while a conversion is in progress.
- `OverSig` out 1: high when the last converted value exceeded 9999; updates together with `NumberSig`.

## Operation
- States: IDLE and SHIFT.
- **IDLE**
  - If `StartSig` = 1, load the shift register as {20'b0 BCD field (5 digits), `BinData`}.
  - Clear the iteration counter, then enter SHIFT.
- **SHIFT, each cycle**
  - Every BCD nibble ≥ 5 gets +3 (nibble-local add; no carry between nibbles).
  - Then shift the whole {BCD, binary} register left by 1.
  - The counter increments; on the `BIN_W`-th shift, return to IDLE.
- **Completion (edge of the final shift)**
  - `NumberSig` loads the low 4 BCD digits; see Configuration for overflow handling.
  - `OverSig` loads 1 if the 5th (ten-thousands) digit is nonzero, else 0.
  - `DoneSig` is 1 for exactly the following cycle.
- A 5th BCD digit is kept internally; 16383 needs it, and its width is 4 bits.
- `StartSig` while `BusySig` = 1 is ignored; it is not queued.
- `BinData` changes during SHIFT have no effect.
- **Reset**
  - `RST` = 1 at any edge forces IDLE and clears the counter and shift register.
  - Outputs after reset: `NumberSig` = 16'h0000, `DoneSig` = 0, `BusySig` = 0, `OverSig` = 0.
  - A conversion cut off by reset produces no `DoneSig` and leaves `NumberSig` at 0.
  - `RST` has priority over `StartSig` on the same edge.

## Timing
- Start accepted at edge k: `BusySig` = 1 from after edge k through edge k+`BIN_W`.
- Final shift at edge k+`BIN_W`; `NumberSig` and `OverSig` valid, and `DoneSig` = 1, in the cycle after that edge.
- `BusySig` = 0 during the `DoneSig` cycle.
- Back-to-back: `StartSig` in the `DoneSig` cycle is accepted, giving a throughput of one conversion per `BIN_W`+1 cycles.
- Latency from `StartSig` asserted to `DoneSig` asserted is `BIN_W`+1 cycles (15 cycles at default).
- All outputs come directly from registers; no combinational path from inputs to outputs.

## Configuration
- Macro: `BCD_SATURATE_EN`.
- **Defined:** if the result exceeds 9999, `NumberSig` = 16'h9999 and `OverSig` = 1.
- **Undefined:** `NumberSig` = low four digits of the true decimal value (value mod 10000), with `OverSig` still reported.
- Either way, values ≤ 9999 convert exactly and give `OverSig` = 0.

## Test plan
- **Reset:** hold `RST` 3 cycles → `NumberSig` = 16'h0000 and `DoneSig`, `BusySig`, `OverSig` = 0; pulse `StartSig` with `BinData` = 1234 → `DoneSig` exactly 15 cycles later, one cycle wide, `NumberSig` = 16'h1234, `OverSig` = 0.
- **Boundaries:** convert 0, 9, 10, 99, 9999 → 16'h0000, 16'h0009, 16'h0010, 16'h0099, 16'h9999, each with `OverSig` = 0.
- **Overflow:** `BinData` = 12345 → `OverSig` = 1; `NumberSig` = 16'h9999 with `BCD_SATURATE_EN`, 16'h2345 without. Repeat with 16383 → 16'h9999 or 16'h6383 respectively.
- **Busy/back-to-back:**
  - Pulse `StartSig` with 5678, then again 4 cycles later with 1111 → second request ignored; only one `DoneSig`, `NumberSig` = 16'h5678.
  - Then `StartSig` with 4321 during the `DoneSig` cycle → accepted; second `DoneSig` 15 cycles later, `NumberSig` = 16'h4321.
- **Reset mid-operation:** after converting 4321, start 8765 and assert `RST` at the 5th SHIFT cycle → no `DoneSig`, `NumberSig` = 16'h0000, `BusySig` = 0; next start with 42 → 16'h0042.
- **Exhaustive sweep:** run all `BinData` 0..16383 through a reference-model checker → every result matches the decimal value under the active macro setting.

Source files
------------

// File: rtl/bin_to_bcd_module.sv
// Iterative double-dabble binary-to-BCD converter, one shift per clock.
// Define BCD_SATURATE_EN to clamp results above 9999 to 16'h9999.
module bin_to_bcd_module #(
   parameter int BIN_W = 14
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             StartSig,
   input  logic [BIN_W-1:0] BinData,
   output logic [15:0]      NumberSig,
   output logic             DoneSig,
   output logic             BusySig,
   output logic             OverSig
);

   localparam int SR_W  = 20 + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   state_e            state_q;
   logic [SR_W-1:0]   shift_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [15:0]       number_q;
   logic              done_q;
   logic              busy_q;
   logic              over_q;

   logic [SR_W-1:0]   adj_d;
   logic [SR_W-1:0]   shift_d;
   logic [19:0]       bcd_d;
   logic [15:0]       result_d;
   logic              over_d;
   logic              last_shift_d;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      adj_d = shift_q;
      for (int i = 0; i < 5; i++) begin
         // Nibble-local +3: no carry is allowed to spill into the next digit.
         if (shift_q[BIN_W + 4*i +: 4] >= 4'd5)
            adj_d[BIN_W + 4*i +: 4] = shift_q[BIN_W + 4*i +: 4] + 4'd3;
      end
      shift_d      = adj_d << 1;
      bcd_d        = shift_d[SR_W-1 -: 20];
      over_d       = (bcd_d[19:16] != 4'd0);
      last_shift_d = (cnt_q == CNT_W'(BIN_W - 1));
`ifdef BCD_SATURATE_EN
      result_d     = over_d ? 16'h9999 : bcd_d[15:0];
`else
      result_d     = bcd_d[15:0];
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         number_q <= 16'h0000;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (StartSig) begin
                  shift_q <= {20'b0, BinData};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               shift_q <= shift_d;
               cnt_q   <= cnt_q + 1'b1;
               if (last_shift_d) begin
                  number_q <= result_d;
                  over_q   <= over_d;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign NumberSig = number_q;
   assign DoneSig   = done_q;
   assign BusySig   = busy_q;
   assign OverSig   = over_q;

endmodule
